// File: rtl/divclk_monitor_pkg.sv
// ----------------------------------------------------------------------------
// divclk_monitor_pkg
//   Shared definitions for the divided-clock monitor.
//   - state_t   : monitor FSM states. The encodings are fixed so divider benches
//                 can decode the status from a raw 2-bit value.
//   - low_bound : lower edge of the tolerance window, clamped at zero so a
//                 tolerance wider than the expected half-period cannot wrap.
// ----------------------------------------------------------------------------
package divclk_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Lower tolerance bound. It saturates at zero instead of going negative.
    function automatic int unsigned low_bound(input int unsigned exp_half,
                                              input int unsigned tol);
        return (exp_half > tol) ? (exp_half - tol) : 0;
    endfunction

endpackage

// File: rtl/divclk_monitor_edge_sync.sv
// ----------------------------------------------------------------------------
// edge_sync
//   Brings a possibly asynchronous 1-bit level into the clk domain through a
//   two-flop synchronizer. It then flags every change of the synchronized
//   level, so both rising and falling edges are reported.
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high reset, all flops cleared to 0
//   async_in in   raw input level
//   toggled  out  high for one cycle after the synchronized level changes
// ----------------------------------------------------------------------------
module edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic toggled
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two synchronizer stages followed by a history flop. The history flop
    // lets a change of the synchronized level be detected one cycle after
    // it appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // A rising edge and a falling edge both count as one half-period boundary.
    assign toggled = sync2 ^ prev;

endmodule

// File: rtl/divclk_monitor.sv
// ----------------------------------------------------------------------------
// divclk_monitor
//   Receive-side checker for a divided square wave. It measures every
//   half-period in clk cycles and checks each one against the expected value
//   +/- TOL. It raises locked after LOCK_COUNT good half-periods in a row.
// Ports
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   enable       in   1 = monitor runs; 0 = idle with locked forced low
//   sig_in       in   divided square wave, may be asynchronous to clk
//   half_period  out  last completed measurement, held between measurements
//   meas_valid   out  one-cycle pulse when half_period is updated
//   locked       out  LOCK_COUNT consecutive in-tolerance measurements seen
//   err          out  one-cycle pulse on an out-of-tolerance edge or a timeout
// ----------------------------------------------------------------------------
module divclk_monitor
    import divclk_monitor_pkg::*;
#(
    parameter int EXP_HALF   = 5000000,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W:0]    LO_BOUND  = (CNT_W+1)'(low_bound(EXP_HALF, TOL));
    localparam logic [CNT_W:0]    HI_BOUND  = (CNT_W+1)'(EXP_HALF + TOL);
    localparam logic [CNT_W:0]    TIMEOUT   = (CNT_W+1)'(EXP_HALF + TOL + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_COUNT);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_next;
    logic              meas_valid_next;
    logic              err_next;
    logic              locked_next;
    logic              toggled;
    logic              in_tol;
    logic              timed_out;

    edge_sync u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (sig_in),
        .toggled  (toggled)
    );

    // The counter value in an edge cycle is the measured half-period. The
    // window test uses one extra bit so that neither bound can wrap.
    // A timeout only counts when there is no edge in that cycle, so an edge
    // that lands exactly at the limit is still measured.
    assign in_tol    = ({1'b0, cnt} >= LO_BOUND) && ({1'b0, cnt} <= HI_BOUND);
    assign timed_out = ({1'b0, cnt} == TIMEOUT) && !toggled;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Dropping enable returns to IDLE from any state.
    // ACQUIRE waits for one edge only to start the counter. A timeout while
    // tracking sends the FSM back to ACQUIRE, because the phase is lost.
    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    state_next = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (toggled) begin
                        state_next = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (toggled) begin
                        if (in_tol && (good == GOOD_LAST)) begin
                            state_next = ST_LOCKED;
                        end
                    end else if (timed_out) begin
                        state_next = ST_ACQUIRE;
                    end
                end
                ST_LOCKED: begin
                    if (toggled) begin
                        if (!in_tol) begin
                            state_next = ST_TRACK;
                        end
                    end else if (timed_out) begin
                        state_next = ST_ACQUIRE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values.
    // - Every edge restarts the counter at 1.
    // - Between edges the counter counts up and saturates.
    // - The good counter saturates at LOCK_COUNT.
    // - locked rises in the same cycle as the meas_valid pulse that completes
    //   the run of good measurements.
    always_comb begin
        cnt_next        = toggled ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);
        good_next       = good;
        meas_valid_next = 1'b0;
        err_next        = 1'b0;
        locked_next     = locked;
        if (!enable) begin
            cnt_next    = '0;
            good_next   = '0;
            locked_next = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_next    = '0;
                    good_next   = '0;
                    locked_next = 1'b0;
                end
                ST_ACQUIRE: begin
                    locked_next = 1'b0;
                end
                ST_TRACK, ST_LOCKED: begin
                    if (toggled) begin
                        meas_valid_next = 1'b1;
                        if (in_tol) begin
                            good_next   = (good == GOOD_MAX) ? good : good + 1'b1;
                            locked_next = (state == ST_LOCKED) || (good == GOOD_LAST);
                        end else begin
                            good_next   = '0;
                            err_next    = 1'b1;
                            locked_next = 1'b0;
                        end
                    end else if (timed_out) begin
                        good_next   = '0;
                        err_next    = 1'b1;
                        locked_next = 1'b0;
                    end
                end
                default: begin
                    locked_next = 1'b0;
                end
            endcase
        end
    end

    // Registered datapath and outputs. half_period only loads on a
    // measurement, so it keeps its value across idle periods and timeouts.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            good        <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            good       <= good_next;
            meas_valid <= meas_valid_next;
            err        <= err_next;
            locked     <= locked_next;
            if (meas_valid_next) begin
                half_period <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_divclk_monitor.sv
// ----------------------------------------------------------------------------
// tb_divclk_monitor
//   Bench for divclk_monitor with EXP_HALF=5, TOL=1, LOCK_COUNT=3, CNT_W=8.
//   A reference model stamps each detected input change with its cycle number
//   and derives the expected outputs from the elapsed time between changes.
//   Directed scenarios run first, followed by randomized segments.
// ----------------------------------------------------------------------------
module tb_divclk_monitor;

    localparam int EXP_HALF   = 5;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 3;
    localparam int CNT_W      = 8;
    localparam int LIMIT      = EXP_HALF + TOL + 1;

    localparam int M_OFF     = 0;
    localparam int M_WAIT    = 1;
    localparam int M_MEASURE = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             err;

    int checks   = 0;
    int failures = 0;

    int               ref_mode   = M_OFF;
    int               ref_run    = 0;
    int               ref_last   = 0;
    int               ref_cycle  = 0;
    logic             ref_locked = 1'b0;
    logic [CNT_W-1:0] ref_hp     = '0;
    logic             ref_mv     = 1'b0;
    logic             ref_err    = 1'b0;
    bit               seen[$]    = '{1'b0, 1'b0, 1'b0};

    divclk_monitor #(
        .EXP_HALF   (EXP_HALF),
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sig_in      (sig_in),
        .half_period (half_period),
        .meas_valid  (meas_valid),
        .locked      (locked),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Compare one observed value against the required value.
    task automatic checkOutput(input string tag, input logic [CNT_W-1:0] observed,
                               input logic [CNT_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d cycle=%0d",
                   tag, observed, expected, ref_cycle);
        end
    endtask

    // Reference model, advanced once per clock.
    // seen[] holds the recent sampled input levels. The model sees an input
    // change in the cycle where the two older levels differ. The elapsed
    // cycle count between changes is the expected measurement.
    task automatic modelStep(input logic rst, input logic en, input logic s);
        int  elapsed;
        bit  change;
        ref_cycle++;
        change  = (seen[1] != seen[0]);
        ref_mv  = 1'b0;
        ref_err = 1'b0;
        if (rst) begin
            ref_hp     = '0;
            ref_locked = 1'b0;
            ref_run    = 0;
            ref_mode   = M_OFF;
            seen       = '{1'b0, 1'b0, 1'b0};
        end else begin
            if (!en) begin
                ref_mode   = M_OFF;
                ref_locked = 1'b0;
                ref_run    = 0;
            end else if (ref_mode == M_OFF) begin
                ref_mode = M_WAIT;
            end else if (ref_mode == M_WAIT) begin
                if (change) begin
                    ref_last = ref_cycle;
                    ref_mode = M_MEASURE;
                end
            end else begin
                elapsed = ref_cycle - ref_last;
                if (change) begin
                    ref_hp   = CNT_W'(elapsed);
                    ref_mv   = 1'b1;
                    ref_last = ref_cycle;
                    if (elapsed >= EXP_HALF - TOL && elapsed <= EXP_HALF + TOL) begin
                        ref_run = (ref_run < LOCK_COUNT) ? ref_run + 1 : LOCK_COUNT;
                        if (ref_run == LOCK_COUNT) ref_locked = 1'b1;
                    end else begin
                        ref_run    = 0;
                        ref_err    = 1'b1;
                        ref_locked = 1'b0;
                    end
                end else if (elapsed == LIMIT) begin
                    ref_err    = 1'b1;
                    ref_locked = 1'b0;
                    ref_run    = 0;
                    ref_mode   = M_WAIT;
                end
            end
            seen.push_back(s);
            void'(seen.pop_front());
        end
    endtask

    // Drive one clock of inputs, then check every output against the model.
    task automatic applyStimulus(input logic rst, input logic en, input logic s);
        reset  = rst;
        enable = en;
        sig_in = s;
        @(posedge clk);
        #1;
        modelStep(rst, en, s);
        checkOutput("half_period", half_period, ref_hp);
        checkOutput("meas_valid", CNT_W'(meas_valid), CNT_W'(ref_mv));
        checkOutput("err", CNT_W'(err), CNT_W'(ref_err));
        checkOutput("locked", CNT_W'(locked), CNT_W'(ref_locked));
    endtask

    task automatic holdCycles(input int n);
        repeat (n) applyStimulus(1'b0, enable, sig_in);
    endtask

    task automatic halfPeriods(input int n, input int count);
        repeat (count) begin
            applyStimulus(1'b0, enable, ~sig_in);
            repeat (n - 1) applyStimulus(1'b0, enable, sig_in);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;

        // Scenario 1: reset, enable, steady half-period of 5 -> lock.
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_half_period", half_period, '0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        holdCycles(2);
        halfPeriods(5, 6);
        checkOutput("s1_locked", CNT_W'(locked), CNT_W'(1));
        checkOutput("s1_half_period", half_period, CNT_W'(5));

        // Scenario 2: one long half-period of 7, then relock at 5.
        halfPeriods(7, 1);
        halfPeriods(5, 5);
        checkOutput("s2_relocked", CNT_W'(locked), CNT_W'(1));

        // Scenario 3: stuck input times out, then resume at 4.
        holdCycles(12);
        checkOutput("s3_unlocked", CNT_W'(locked), CNT_W'(0));
        halfPeriods(4, 6);
        checkOutput("s3_relocked", CNT_W'(locked), CNT_W'(1));

        // Scenario 4: drop enable mid-half-period for 10 cycles.
        halfPeriods(5, 4);
        applyStimulus(1'b0, 1'b1, ~sig_in);
        holdCycles(1);
        repeat (10) applyStimulus(1'b0, 1'b0, sig_in);
        checkOutput("s4_hold_half_period", half_period, CNT_W'(5));
        applyStimulus(1'b0, 1'b1, sig_in);
        holdCycles(2);
        halfPeriods(5, 6);

        // Scenario 5: reset while locked.
        applyStimulus(1'b1, 1'b1, sig_in);
        checkOutput("s5_reset_half_period", half_period, '0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        holdCycles(2);
        halfPeriods(5, 6);

        // Scenario 6: too short a half-period never locks.
        halfPeriods(3, 10);
        checkOutput("s6_never_locked", CNT_W'(locked), CNT_W'(0));

        // Randomized segments mixing periods, stalls, enable drops and resets.
        for (int seg = 0; seg < 80; seg++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                halfPeriods($urandom_range(2, 9), $urandom_range(1, 5));
            end else if (kind == 6) begin
                holdCycles($urandom_range(3, 12));
            end else if (kind == 7) begin
                repeat ($urandom_range(1, 8)) applyStimulus(1'b0, 1'b0, sig_in);
                applyStimulus(1'b0, 1'b1, sig_in);
            end else if (kind == 8) begin
                repeat ($urandom_range(1, 2)) applyStimulus(1'b1, enable, sig_in);
                applyStimulus(1'b0, 1'b1, sig_in);
            end else begin
                repeat ($urandom_range(2, 6)) halfPeriods($urandom_range(4, 6), 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
